reorder_buffer: RTL and testbench

//  Circular in-order reorder buffer for the Tomasulo core. Allocates a tag per issued instruction.
//  Tag = slot+1; tag 0 means "no producer". Tag goes to regfile Q_value on issue.

---
 rtl/core_pkg.sv | 36 +++
 rtl/reorder_buffer.sv | 198 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared reorder-buffer definitions: geometry, tag/slot types and the
// tag <-> slot index helpers used by issue, writeback and query logic.
package core_pkg;

    localparam int ROB_DEPTH      = 16;
    localparam int Q_WIDTH        = 5;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int IDX_WIDTH      = $clog2(ROB_DEPTH);
    localparam int CNT_WIDTH      = IDX_WIDTH + 1;

    typedef logic [Q_WIDTH-1:0]        tag_t;
    typedef logic [IDX_WIDTH-1:0]      idx_t;
    typedef logic [CNT_WIDTH-1:0]      cnt_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_t;
    typedef logic [31:0]               word_t;

    // Tag 0 is reserved to mean "value already in the register file".
    localparam tag_t TAG_NONE = '0;

    // True when the tag names a real slot (1..ROB_DEPTH).
    function automatic logic tag_is_slot(input tag_t tag);
        return (tag != TAG_NONE) && (tag <= tag_t'(ROB_DEPTH));
    endfunction

    // Tags are slot+1 so that slot 0 never collides with TAG_NONE.
    function automatic idx_t tag_to_idx(input tag_t tag);
        tag_t slot;
        slot = tag - tag_t'(1);
        return slot[IDX_WIDTH-1:0];
    endfunction

    function automatic tag_t idx_to_tag(input idx_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Hands out a tag per issued instruction,
// captures CDB results, answers operand lookups and retires the head entry
// in program order onto the register-file commit port.
module reorder_buffer
    import core_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,

    input  logic        issue_valid,
    input  logic        issue_has_rd,
    input  reg_t        issue_rd,
    output logic        issue_ready,
    output tag_t        issue_tag,

    input  logic        wb_valid,
    input  tag_t        wb_tag,
    input  word_t       wb_value,

    input  tag_t        q1_tag,
    input  tag_t        q2_tag,
    output logic        q1_ready,
    output logic        q2_ready,
    output word_t       q1_value,
    output word_t       q2_value,

    output logic        has_commit,
    output reg_t        commit_target,
    output tag_t        Commit_Q,
    output word_t       Commit_V
);

    // Ring pointers and occupancy.
    idx_t head_reg;
    idx_t tail_reg;
    cnt_t count_reg;

    // Per-slot state gathered from the entry generate blocks so it can be
    // indexed by head pointer / tag.
    logic [ROB_DEPTH-1:0] busy_vec;
    logic [ROB_DEPTH-1:0] ready_vec;
    logic [ROB_DEPTH-1:0] has_rd_vec;
    reg_t                 rd_arr    [ROB_DEPTH];
    word_t                value_arr [ROB_DEPTH];

    // Cycle-level events, all evaluated on pre-edge state. A frozen cycle
    // (rdy_in low) makes every event vanish, and a flush overrides the rest.
    logic flush_fire;
    logic issue_fire;
    logic wb_fire;
    logic commit_fire;
    logic commit_pulse;
    idx_t wb_idx;

    assign issue_ready  = (count_reg < cnt_t'(ROB_DEPTH));
    assign issue_tag    = idx_to_tag(tail_reg);

    assign wb_idx       = tag_to_idx(wb_tag);
    assign flush_fire   = rdy_in && flush_in;
    assign issue_fire   = rdy_in && !flush_in && issue_valid && issue_ready;
    assign wb_fire      = rdy_in && !flush_in && wb_valid && tag_is_slot(wb_tag)
                          && busy_vec[wb_idx];
    // The head's ready bit is the registered one, so a result broadcast this
    // cycle can only retire on the next edge.
    assign commit_fire  = rdy_in && !flush_in && busy_vec[head_reg] && ready_vec[head_reg];
    // Entries without a real destination (or writing x0) retire silently.
    assign commit_pulse = commit_fire && has_rd_vec[head_reg] && (rd_arr[head_reg] != '0);

    genvar gi;
    generate
        for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
            logic  busy_reg;
            logic  ready_reg;
            logic  has_rd_reg;
            reg_t  rd_reg;
            word_t value_reg;

            logic is_tail;
            logic is_head;
            logic is_wb;

            assign is_tail = (tail_reg == idx_t'(gi));
            assign is_head = (head_reg == idx_t'(gi));
            assign is_wb   = (wb_idx   == idx_t'(gi));

            // Slot lifecycle: allocate on issue, fill on writeback, free on commit.
            // Issue and commit never target the same slot in one cycle (a full
            // buffer blocks issue), and commit wins over a late writeback.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    busy_reg   <= 1'b0;
                    ready_reg  <= 1'b0;
                    has_rd_reg <= 1'b0;
                    rd_reg     <= '0;
                    value_reg  <= '0;
                end else if (flush_fire) begin
                    busy_reg   <= 1'b0;
                    ready_reg  <= 1'b0;
                end else if (issue_fire && is_tail) begin
                    busy_reg   <= 1'b1;
                    ready_reg  <= 1'b0;
                    has_rd_reg <= issue_has_rd;
                    rd_reg     <= issue_rd;
                end else if (commit_fire && is_head) begin
                    busy_reg   <= 1'b0;
                    ready_reg  <= 1'b0;
                end else if (wb_fire && is_wb) begin
                    ready_reg  <= 1'b1;
                    value_reg  <= wb_value;
                end
            end

            assign busy_vec[gi]   = busy_reg;
            assign ready_vec[gi]  = ready_reg;
            assign has_rd_vec[gi] = has_rd_reg;
            assign rd_arr[gi]     = rd_reg;
            assign value_arr[gi]  = value_reg;
        end
    endgenerate

    // Head/tail advance and occupancy; issue+commit together leave count alone.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_fire) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (issue_fire) begin
                tail_reg <= tail_reg + idx_t'(1);
            end
            if (commit_fire) begin
                head_reg <= head_reg + idx_t'(1);
            end
            case ({issue_fire, commit_fire})
                2'b10:   count_reg <= count_reg + cnt_t'(1);
                2'b01:   count_reg <= count_reg - cnt_t'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered commit port: one-cycle pulse, payload holds between commits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            has_commit    <= 1'b0;
            commit_target <= '0;
            Commit_Q      <= TAG_NONE;
            Commit_V      <= '0;
        end else if (!rdy_in || flush_in) begin
            has_commit    <= 1'b0;
        end else begin
            has_commit    <= commit_pulse;
            if (commit_pulse) begin
                commit_target <= rd_arr[head_reg];
                Commit_Q      <= idx_to_tag(head_reg);
                Commit_V      <= value_arr[head_reg];
            end
        end
    end

    // Operand lookup ports share one implementation.
    tag_t  q_tag_arr   [2];
    logic  q_ready_arr [2];
    word_t q_value_arr [2];

    assign q_tag_arr[0] = q1_tag;
    assign q_tag_arr[1] = q2_tag;
    assign q1_ready     = q_ready_arr[0];
    assign q2_ready     = q_ready_arr[1];
    assign q1_value     = q_value_arr[0];
    assign q2_value     = q_value_arr[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            idx_t q_idx;
            assign q_idx = tag_to_idx(q_tag_arr[gi]);

            // Lookup with same-cycle CDB forwarding so issue never misses a
            // result that is being broadcast right now.
            always_comb begin
                q_ready_arr[gi] = 1'b0;
                q_value_arr[gi] = '0;
                if (tag_is_slot(q_tag_arr[gi])) begin
                    if (wb_valid && (wb_tag == q_tag_arr[gi])) begin
                        q_ready_arr[gi] = 1'b1;
                        q_value_arr[gi] = wb_value;
                    end else if (busy_vec[q_idx] && ready_vec[q_idx]) begin
                        q_ready_arr[gi] = 1'b1;
                        q_value_arr[gi] = value_arr[q_idx];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: scoreboard of expected commits in program order,
// pushed at issue and popped by a monitor on every commit pulse.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  issue_tag;
    logic        wb_valid;
    logic [4:0]  wb_tag;
    logic [31:0] wb_value;
    logic [4:0]  q1_tag;
    logic [4:0]  q2_tag;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_value;
    logic [31:0] q2_value;
    logic        has_commit;
    logic [4:0]  commit_target;
    logic [4:0]  Commit_Q;
    logic [31:0] Commit_V;

    reorder_buffer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .issue_valid   (issue_valid),
        .issue_has_rd  (issue_has_rd),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .issue_tag     (issue_tag),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_value      (wb_value),
        .q1_tag        (q1_tag),
        .q2_tag        (q2_tag),
        .q1_ready      (q1_ready),
        .q2_ready      (q2_ready),
        .q1_value      (q1_value),
        .q2_value      (q2_value),
        .has_commit    (has_commit),
        .commit_target (commit_target),
        .Commit_Q      (Commit_Q),
        .Commit_V      (Commit_V)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0] rd;
        logic [4:0] tag;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_val [32];
    int          m_tail;
    int          n_checks;
    int          n_fail;
    int          commit_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Commit monitor: every pulse must match the oldest outstanding entry.
    always begin
        exp_t e;
        @(posedge clk_in);
        #1;
        if (has_commit) begin
            commit_count++;
            $display("commit rd=%0d tag=%0d value=0x%08h", commit_target, Commit_Q, Commit_V);
            if (sb.size() == 0) begin
                check("commit_unexpected", 32'(has_commit), 32'd0);
            end else begin
                e = sb.pop_front();
                check("commit_target", 32'(commit_target), 32'(e.rd));
                check("Commit_Q", 32'(Commit_Q), 32'(e.tag));
                check("Commit_V", Commit_V, exp_val[e.tag]);
            end
        end
    end

    task automatic clear_inputs();
        issue_valid  = 1'b0;
        issue_has_rd = 1'b0;
        issue_rd     = '0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        wb_value     = '0;
        flush_in     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        sb.delete();
        m_tail = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Issue one instruction; the caller says whether it should be accepted.
    task automatic do_issue(input logic [4:0] rd, input logic has, input logic exp_ready);
        exp_t e;
        issue_valid  = 1'b1;
        issue_has_rd = has;
        issue_rd     = rd;
        #1;
        check("issue_ready", 32'(issue_ready), 32'(exp_ready));
        check("issue_tag", 32'(issue_tag), 32'(m_tail + 1));
        $display("issue rd=%0d has_rd=%0d tag=%0d accept=%0d", rd, has, m_tail + 1, exp_ready);
        if (exp_ready) begin
            if (has && rd != 5'd0) begin
                e.rd  = rd;
                e.tag = 5'(m_tail + 1);
                sb.push_back(e);
            end
            m_tail = (m_tail + 1) % 16;
        end
        @(negedge clk_in);
        issue_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] tag, input logic [31:0] val);
        wb_valid = 1'b1;
        wb_tag   = tag;
        wb_value = val;
        exp_val[tag] = val;
        $display("wb tag=%0d value=0x%08h", tag, val);
        @(negedge clk_in);
        wb_valid = 1'b0;
    endtask

    int c0;

    initial begin
        n_checks = 0;
        n_fail = 0;
        commit_count = 0;
        q1_tag = '0;
        q2_tag = '0;
        for (int i = 0; i < 32; i++) exp_val[i] = '0;

        // 1: reset state and a single issue -> wb -> commit
        do_reset();
        q1_tag = 5'd1;
        #1;
        check("rst_has_commit", 32'(has_commit), 32'd0);
        check("rst_commit_target", 32'(commit_target), 32'd0);
        check("rst_Commit_Q", 32'(Commit_Q), 32'd0);
        check("rst_Commit_V", Commit_V, 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_q1_ready", 32'(q1_ready), 32'd0);
        do_issue(5'd3, 1'b1, 1'b1);
        do_wb(5'd1, 32'hDEAD);
        check("t1_no_commit_wb_cycle", 32'(has_commit), 32'd0);
        idle(1);
        check("t1_has_commit", 32'(has_commit), 32'd1);
        check("t1_commit_target", 32'(commit_target), 32'd3);
        check("t1_Commit_Q", 32'(Commit_Q), 32'd1);
        check("t1_Commit_V", Commit_V, 32'hDEAD);
        idle(1);
        check("t1_pulse_one_cycle", 32'(has_commit), 32'd0);

        // 2: fill all 16 slots, blocked issue, tag wrap after head commit
        do_reset();
        for (int i = 0; i < 16; i++) do_issue(5'(i + 1), 1'b1, 1'b1);
        #1;
        check("t2_full_ready", 32'(issue_ready), 32'd0);
        do_issue(5'd20, 1'b1, 1'b0);
        do_wb(5'd1, 32'h1111);
        do_issue(5'd21, 1'b1, 1'b0);   // commit happens this cycle; still blocked
        do_issue(5'd22, 1'b1, 1'b1);   // reuses tag 1
        #1;
        check("t2_full_again", 32'(issue_ready), 32'd0);

        // 3: out-of-order writeback holds retirement until the head is written
        do_reset();
        do_issue(5'd5, 1'b1, 1'b1);
        do_issue(5'd6, 1'b1, 1'b1);
        do_wb(5'd2, 32'h22);
        c0 = commit_count;
        idle(3);
        check("t3_no_commit_ooo", 32'(commit_count - c0), 32'd0);
        q1_tag = 5'd2;
        #1;
        check("t3_q1_ready", 32'(q1_ready), 32'd1);
        check("t3_q1_value", q1_value, 32'h22);
        do_wb(5'd1, 32'h11);
        check("t3_no_commit_wb_cycle", 32'(has_commit), 32'd0);
        idle(1);
        check("t3_first_commit", 32'(has_commit), 32'd1);
        check("t3_first_Q", 32'(Commit_Q), 32'd1);
        idle(1);
        check("t3_second_commit", 32'(has_commit), 32'd1);
        check("t3_second_Q", 32'(Commit_Q), 32'd2);
        idle(1);
        check("t3_done", 32'(has_commit), 32'd0);

        // 4: query forwarding, tag 0 lookups, silent retire of rd=0
        do_reset();
        for (int i = 0; i < 4; i++) do_issue(5'(7 + i), 1'b1, 1'b1);
        wb_valid = 1'b1;
        wb_tag   = 5'd4;
        wb_value = 32'd7;
        exp_val[4] = 32'd7;
        q1_tag = 5'd4;
        q2_tag = 5'd3;
        #1;
        check("t4_fwd_ready", 32'(q1_ready), 32'd1);
        check("t4_fwd_value", q1_value, 32'd7);
        check("t4_q2_not_ready", 32'(q2_ready), 32'd0);
        @(negedge clk_in);
        wb_valid = 1'b0;
        #1;
        check("t4_stored_ready", 32'(q1_ready), 32'd1);
        check("t4_stored_value", q1_value, 32'd7);
        wb_valid = 1'b1;
        wb_tag   = 5'd0;
        wb_value = 32'd5;
        q2_tag   = 5'd0;
        #1;
        check("t4_tag0_ready", 32'(q2_ready), 32'd0);
        check("t4_tag0_value", q2_value, 32'd0);
        @(negedge clk_in);
        wb_valid = 1'b0;
        do_issue(5'd0, 1'b1, 1'b1);
        c0 = commit_count;
        do_wb(5'd1, 32'hA001);
        do_wb(5'd2, 32'hA002);
        do_wb(5'd3, 32'hA003);
        do_wb(5'd5, 32'hA005);
        idle(4);
        check("t4_commit_count", 32'(commit_count - c0), 32'd4);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: flush with 5 busy entries while issue, wb and commit all pending
        for (int i = 0; i < 5; i++) do_issue(5'(11 + i), 1'b1, 1'b1);
        do_wb(5'd6, 32'h66);
        flush_in     = 1'b1;
        issue_valid  = 1'b1;
        issue_has_rd = 1'b1;
        issue_rd     = 5'd16;
        wb_valid     = 1'b1;
        wb_tag       = 5'd7;
        wb_value     = 32'h77;
        sb.delete();
        @(negedge clk_in);
        clear_inputs();
        m_tail = 0;
        q1_tag = 5'd7;
        #1;
        check("t5_issue_tag", 32'(issue_tag), 32'd1);
        check("t5_issue_ready", 32'(issue_ready), 32'd1);
        check("t5_has_commit", 32'(has_commit), 32'd0);
        check("t5_hold_target", 32'(commit_target), 32'd10);
        check("t5_hold_Q", 32'(Commit_Q), 32'd4);
        check("t5_hold_V", Commit_V, 32'd7);
        check("t5_q1_cleared", 32'(q1_ready), 32'd0);
        idle(2);
        for (int i = 0; i < 15; i++) do_issue(5'd0, 1'b0, 1'b1);
        #1;
        check("t5_15_ready", 32'(issue_ready), 32'd1);
        do_issue(5'd0, 1'b0, 1'b1);
        #1;
        check("t5_16_full", 32'(issue_ready), 32'd0);

        // 6: rdy_in low freezes everything mid-traffic
        do_reset();
        #1;
        check("t6_rst_target", 32'(commit_target), 32'd0);
        check("t6_rst_V", Commit_V, 32'd0);
        do_issue(5'd1, 1'b1, 1'b1);
        do_issue(5'd2, 1'b1, 1'b1);
        do_issue(5'd3, 1'b1, 1'b1);
        do_wb(5'd1, 32'hA1);
        c0 = commit_count;
        rdy_in       = 1'b0;
        issue_valid  = 1'b1;
        issue_has_rd = 1'b1;
        issue_rd     = 5'd9;
        wb_valid     = 1'b1;
        wb_tag       = 5'd2;
        wb_value     = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            #1;
            check("t6_frozen_commit", 32'(has_commit), 32'd0);
            check("t6_frozen_tag", 32'(issue_tag), 32'd4);
        end
        check("t6_frozen_count", 32'(commit_count - c0), 32'd0);
        rdy_in = 1'b1;
        clear_inputs();
        q1_tag = 5'd2;
        #1;
        check("t6_wb_ignored", 32'(q1_ready), 32'd0);
        @(negedge clk_in);
        check("t6_resume_commit", 32'(has_commit), 32'd1);
        check("t6_resume_Q", 32'(Commit_Q), 32'd1);
        check("t6_resume_V", Commit_V, 32'hA1);
        do_wb(5'd2, 32'hB2);
        do_wb(5'd3, 32'hC3);
        idle(3);
        do_issue(5'd4, 1'b1, 1'b1);
        do_wb(5'd4, 32'hD4);
        idle(3);
        check("t6_commit_count", 32'(commit_count - c0), 32'd4);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
